arbitro_botoes: RTL

- Front-end controller between the board push-buttons and the stopwatch state machine.
- Synchronises and debounces the three command buttons (conta, pausa, para).
- Arbitrates simultaneous presses by fixed priority.
- Issues exactly one single-cycle command pulse per accepted press, then locks out further commands until all buttons are released.

---
 rtl/arbitro_botoes.sv | 111 +++++++++++
 1 files changed

// File: rtl/arbitro_botoes.sv
// rtl/arbitro_botoes.sv - button synchroniser, debouncer and fixed-priority command arbiter
module arbitro_botoes #(
  parameter int DEBOUNCE    = 1000000,
  parameter bit ATIVO_BAIXO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_conta,
  input  logic       btn_pausa,
  input  logic       btn_para,
  output logic       conta,
  output logic       pausa,
  output logic       para,
  output logic [1:0] ultimo_cmd,
  output logic       conflito,
  output logic       ocupado
);

  localparam int CW = (DEBOUNCE < 1) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [2:0] SOLTO_RAW = {3{ATIVO_BAIXO}};
  localparam logic [CW-1:0] LIMITE = CW'(DEBOUNCE - 1);

  typedef enum logic [1:0] {OCIOSO, EMITE, ESPERA_SOLTAR} estado_t;

  // Bit order everywhere: [0] conta, [1] pausa, [2] para.
  logic [2:0]    raw, s1, s2, nivel, deb, deb_d, ev;
  logic          multi;
  logic [CW-1:0] cnt [3];
  estado_t       estado;

  assign raw   = {btn_para, btn_pausa, btn_conta};
  assign nivel = s2 ^ SOLTO_RAW;
  assign ev    = deb & ~deb_d;
  assign multi = (ev[0] & ev[1]) | (ev[0] & ev[2]) | (ev[1] & ev[2]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= SOLTO_RAW;
      s2    <= SOLTO_RAW;
      deb   <= 3'b000;
      deb_d <= 3'b000;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_d <= deb;
      for (int i = 0; i < 3; i++) begin
        if (nivel[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == LIMITE) begin
          deb[i] <= nivel[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // Command outputs are raised on the transition into EMITE so the pulse spans that state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado     <= OCIOSO;
      conta      <= 1'b0;
      pausa      <= 1'b0;
      para       <= 1'b0;
      ultimo_cmd <= 2'd0;
      conflito   <= 1'b0;
      ocupado    <= 1'b0;
    end else begin
      conta <= 1'b0;
      pausa <= 1'b0;
      para  <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (|ev) begin
            estado  <= EMITE;
            ocupado <= 1'b1;
            if (multi) conflito <= 1'b1;
            if (ev[2]) begin
              para       <= 1'b1;
              ultimo_cmd <= 2'd3;
            end else if (ev[1]) begin
              pausa      <= 1'b1;
              ultimo_cmd <= 2'd2;
            end else begin
              conta      <= 1'b1;
              ultimo_cmd <= 2'd1;
            end
          end
        end
        EMITE: begin
          estado <= ESPERA_SOLTAR;
          if (|ev) conflito <= 1'b1;
        end
        ESPERA_SOLTAR: begin
          if (|ev) conflito <= 1'b1;
          if (deb == 3'b000) begin
            estado  <= OCIOSO;
            ocupado <= 1'b0;
          end
        end
        default: begin
          estado  <= OCIOSO;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule
